cms_stream_controller: RTL and testbench

Sequences the trace output datapath of the continuous monitoring system. Accepts filtered trace items and buffers them in a 2-entry queue. Emits them as an AXI-Stream master with programmable TLAST packetisation, and halts the CPU when back-pressured. Owns the stream-related control registers (TLAST_INTERVAL, HALTING_ON_FULL_FIFO_ENABLED, ARBITRARY_HALT, WFI_STOPPED, CLK_COUNTER, LAST_WRITE_TIMESTAMP) on the shared ctrl address/data bus.

---
 rtl/cms_stream_controller_pkg.sv | 34 +++
 rtl/cms_skid_fifo2.sv | 56 +++++
 rtl/cms_stream_controller.sv | 193 +++++++++++++++++++
 tb/tb_cms_stream_controller.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/cms_stream_controller_pkg.sv
// Shared types and constants for the CMS trace stream controller:
// ctrl address map, stream FSM states and register widths.
package cms_stream_controller_pkg;

    localparam int CTRL_ADDR_WIDTH    = 8;
    localparam int CTRL_DATA_WIDTH    = 64;
    localparam int DROP_COUNTER_WIDTH = 32;
    localparam int TLAST_WIDTH        = 32;

    // New entries go at the end so existing encodings never move.
    typedef enum logic [CTRL_ADDR_WIDTH-1:0] {
        TLAST_INTERVAL               = 8'h00,
        HALTING_ON_FULL_FIFO_ENABLED = 8'h01,
        ARBITRARY_HALT               = 8'h02,
        WFI_STOPPED                  = 8'h03,
        CLK_COUNTER                  = 8'h04,
        LAST_WRITE_TIMESTAMP         = 8'h05,
        DROPPED_ITEMS_COUNT          = 8'h06
    } ctrl_addr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } stream_state_t;

    function automatic logic [DROP_COUNTER_WIDTH-1:0] sat_inc(
        input logic [DROP_COUNTER_WIDTH-1:0] value
    );
        return (value == '1) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/cms_skid_fifo2.sv
// Two-entry first-word-fall-through queue; head is valid whenever count != 0.
// The producer must only push when count < 2 or a pop happens in the same cycle.
module cms_skid_fifo2 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count,
    output logic             full
);

    logic [WIDTH-1:0] slot1;
    logic             do_pop;

    assign do_pop = pop && (count != 2'd0);
    assign full   = (count == 2'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            slot1 <= '0;
            count <= 2'd0;
        end else begin
            case ({push, do_pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head  <= push_data;
                        count <= 2'd1;
                    end else if (count == 2'd1) begin
                        slot1 <= push_data;
                        count <= 2'd2;
                    end
                end
                2'b01: begin
                    head  <= slot1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // Occupancy is unchanged; the queue shifts by one.
                    if (count == 2'd1) begin
                        head <= push_data;
                    end else begin
                        head  <= slot1;
                        slot1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/cms_stream_controller.sv
// Trace stream controller: stream FSM, TLAST packetisation, CPU halt and ctrl registers.
// Optional CMS_STREAM_TIMESTAMP_EN stamps clk_counter into the top field of each beat.
module cms_stream_controller
    import cms_stream_controller_pkg::*;
#(
    parameter int DATA_WIDTH = 1024,
    parameter int CNT_WIDTH  = 64,
    parameter int DROP_WIDTH = DROP_COUNTER_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       trace_start,
    input  logic                       trace_end,
    input  logic                       wfi_detected,
    input  logic                       item_valid,
    input  logic [DATA_WIDTH-1:0]      item_data,
    output logic [DATA_WIDTH-1:0]      m_tdata,
    output logic                       m_tvalid,
    output logic                       m_tlast,
    input  logic                       m_tready,
    output logic                       halt_cpu,
    input  logic [CTRL_ADDR_WIDTH-1:0] ctrl_addr,
    input  logic [CTRL_DATA_WIDTH-1:0] ctrl_wdata,
    input  logic                       ctrl_we,
    output logic [CTRL_DATA_WIDTH-1:0] ctrl_rdata,
    output logic [DROP_WIDTH-1:0]      dropped_items,
    output logic [1:0]                 state_o
);

    stream_state_t state, state_next;

    logic [TLAST_WIDTH-1:0] tlast_interval;
    logic [TLAST_WIDTH-1:0] beat_cnt;
    logic                   halting_en;
    logic                   arbitrary_halt;
    logic                   wfi_stopped;
    logic [CNT_WIDTH-1:0]   clk_counter;
    logic [CNT_WIDTH-1:0]   last_write_ts;
    logic [DROP_WIDTH-1:0]  dropped;

    logic [DATA_WIDTH-1:0]  push_data;
    logic [DATA_WIDTH-1:0]  marker_data;
    logic [DATA_WIDTH-1:0]  fifo_head;
    logic [1:0]             fifo_count;
    logic                   fifo_full;
    logic                   push;
    logic                   pop;
    logic                   drop;
    logic                   marker_valid;
    logic                   tlast_int;
    logic                   interval_hit;
    logic                   beat;

    logic wr_tlast_interval, wr_halting_en, wr_arbitrary_halt, wr_wfi_stopped, wr_clk_counter;

    assign wr_tlast_interval = ctrl_we && (ctrl_addr == TLAST_INTERVAL);
    assign wr_halting_en     = ctrl_we && (ctrl_addr == HALTING_ON_FULL_FIFO_ENABLED);
    assign wr_arbitrary_halt = ctrl_we && (ctrl_addr == ARBITRARY_HALT);
    assign wr_wfi_stopped    = ctrl_we && (ctrl_addr == WFI_STOPPED);
    assign wr_clk_counter    = ctrl_we && (ctrl_addr == CLK_COUNTER);

    always_comb begin
        push_data   = item_data;
        marker_data = '0;
`ifdef CMS_STREAM_TIMESTAMP_EN
        push_data[DATA_WIDTH-1 -: CNT_WIDTH]   = clk_counter;
        marker_data[DATA_WIDTH-1 -: CNT_WIDTH] = clk_counter;
`else
        push_data   = item_data;
        marker_data = '0;
`endif
    end

    cms_skid_fifo2 #(
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full)
    );

    assign pop          = (fifo_count != 2'd0) && m_tready;
    assign interval_hit = (tlast_interval != '0) && (beat_cnt == tlast_interval - 1'b1);
    assign drop         = (state == RUN) && item_valid && fifo_full && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        push         = 1'b0;
        marker_valid = 1'b0;
        tlast_int    = 1'b0;
        case (state)
            IDLE: begin
                if (trace_start) state_next = RUN;
            end
            RUN: begin
                push      = item_valid && (!fifo_full || pop);
                tlast_int = interval_hit;
                if (trace_end || wfi_detected) state_next = FLUSH;
            end
            FLUSH: begin
                tlast_int = (fifo_count == 2'd1);
                if (fifo_count == 2'd0) begin
                    // Close an open packet with a marker beat so the sink sees TLAST.
                    if (beat_cnt != '0) begin
                        marker_valid = 1'b1;
                        tlast_int    = 1'b1;
                        if (m_tready) state_next = DONE;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                if (wr_wfi_stopped && !ctrl_wdata[0]) state_next = IDLE;
                else if (trace_start)                 state_next = RUN;
            end
            default: state_next = IDLE;
        endcase
    end

    assign m_tvalid = (fifo_count != 2'd0) || marker_valid;
    assign m_tdata  = marker_valid ? marker_data : fifo_head;
    assign m_tlast  = tlast_int;
    assign beat     = m_tvalid && m_tready;

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt      <= '0;
            clk_counter   <= '0;
            last_write_ts <= '0;
            dropped       <= '0;
            halt_cpu      <= 1'b0;
        end else begin
            if (beat && tlast_int) beat_cnt <= '0;
            else if (beat)         beat_cnt <= beat_cnt + 1'b1;

            if (wr_clk_counter) clk_counter <= CNT_WIDTH'(ctrl_wdata);
            else                clk_counter <= clk_counter + 1'b1;

            if (pop) last_write_ts <= clk_counter;
            if (drop) dropped <= sat_inc(dropped);

            // Registered halt: the second queue slot absorbs the item that arrives in the latency cycle.
            halt_cpu <= arbitrary_halt || (halting_en && (state == RUN) && (fifo_count != 2'd0));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tlast_interval <= '0;
            halting_en     <= 1'b0;
            arbitrary_halt <= 1'b0;
            wfi_stopped    <= 1'b0;
        end else begin
            if (wr_tlast_interval) tlast_interval <= ctrl_wdata[TLAST_WIDTH-1:0];
            if (wr_halting_en)     halting_en     <= ctrl_wdata[0];
            if (wr_arbitrary_halt) arbitrary_halt <= ctrl_wdata[0];
            if ((state == RUN) && wfi_detected) wfi_stopped <= 1'b1;
            else if (wr_wfi_stopped)            wfi_stopped <= ctrl_wdata[0];
        end
    end

    always_comb begin
        ctrl_rdata = '0;
        case (ctrl_addr)
            TLAST_INTERVAL:               ctrl_rdata = CTRL_DATA_WIDTH'(tlast_interval);
            HALTING_ON_FULL_FIFO_ENABLED: ctrl_rdata = CTRL_DATA_WIDTH'(halting_en);
            ARBITRARY_HALT:               ctrl_rdata = CTRL_DATA_WIDTH'(arbitrary_halt);
            WFI_STOPPED:                  ctrl_rdata = CTRL_DATA_WIDTH'(wfi_stopped);
            CLK_COUNTER:                  ctrl_rdata = CTRL_DATA_WIDTH'(clk_counter);
            LAST_WRITE_TIMESTAMP:         ctrl_rdata = CTRL_DATA_WIDTH'(last_write_ts);
            DROPPED_ITEMS_COUNT:          ctrl_rdata = CTRL_DATA_WIDTH'(dropped);
            default:                      ctrl_rdata = '0;
        endcase
    end

    assign dropped_items = dropped;
    assign state_o       = state;

endmodule

// File: tb/tb_cms_stream_controller.sv
// Directed self-checking bench for cms_stream_controller (default build, no timestamp stamping).
module tb_cms_stream_controller;
    import cms_stream_controller_pkg::*;

    localparam int DW = 128;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       trace_start, trace_end, wfi_detected;
    logic                       item_valid;
    logic [DW-1:0]              item_data;
    logic [DW-1:0]              m_tdata;
    logic                       m_tvalid, m_tlast, m_tready;
    logic                       halt_cpu;
    logic [CTRL_ADDR_WIDTH-1:0] ctrl_addr;
    logic [CTRL_DATA_WIDTH-1:0] ctrl_wdata;
    logic                       ctrl_we;
    logic [CTRL_DATA_WIDTH-1:0] ctrl_rdata;
    logic [31:0]                dropped_items;
    logic [1:0]                 state_o;

    int num_checks = 0;
    int num_errors = 0;

    always #5 clk = ~clk;

    cms_stream_controller #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (64),
        .DROP_WIDTH (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .trace_start   (trace_start),
        .trace_end     (trace_end),
        .wfi_detected  (wfi_detected),
        .item_valid    (item_valid),
        .item_data     (item_data),
        .m_tdata       (m_tdata),
        .m_tvalid      (m_tvalid),
        .m_tlast       (m_tlast),
        .m_tready      (m_tready),
        .halt_cpu      (halt_cpu),
        .ctrl_addr     (ctrl_addr),
        .ctrl_wdata    (ctrl_wdata),
        .ctrl_we       (ctrl_we),
        .ctrl_rdata    (ctrl_rdata),
        .dropped_items (dropped_items),
        .state_o       (state_o)
    );

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ctrl_write(input logic [CTRL_ADDR_WIDTH-1:0] addr, input logic [CTRL_DATA_WIDTH-1:0] data);
        ctrl_addr  = addr;
        ctrl_wdata = data;
        ctrl_we    = 1'b1;
        tick();
        ctrl_we    = 1'b0;
    endtask

    task automatic ctrl_read_check(input string tag, input logic [CTRL_ADDR_WIDTH-1:0] addr,
                                   input logic [CTRL_DATA_WIDTH-1:0] exp);
        ctrl_addr = addr;
        #1;
        check(tag, DW'(ctrl_rdata), DW'(exp));
    endtask

    task automatic start_trace();
        trace_start = 1'b1;
        tick();
        trace_start = 1'b0;
    endtask

    task automatic push_item(input logic [DW-1:0] data);
        item_valid = 1'b1;
        item_data  = data;
        tick();
        item_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        trace_start = 1'b0; trace_end = 1'b0; wfi_detected = 1'b0;
        item_valid = 1'b0; item_data = '0; m_tready = 1'b0;
        ctrl_addr = '0; ctrl_wdata = '0; ctrl_we = 1'b0;
        tick();
        tick();
        check("rst_tvalid", DW'(m_tvalid), 0);
        check("rst_halt", DW'(halt_cpu), 0);
        check("rst_state", DW'(state_o), DW'(IDLE));
        check("rst_dropped", DW'(dropped_items), 0);
        ctrl_read_check("rst_tlast_interval", TLAST_INTERVAL, 0);
        rst = 1'b0;

        // Packetisation: interval 4, 10 items, trace_end alongside item 10
        ctrl_write(TLAST_INTERVAL, 4);
        m_tready = 1'b1;
        start_trace();
        check("pkt_state_run", DW'(state_o), DW'(RUN));
        for (int i = 1; i <= 10; i++) begin
            if (i == 10) trace_end = 1'b1;
            push_item(DW'(i));
            trace_end = 1'b0;
            check($sformatf("pkt_tvalid_%0d", i), DW'(m_tvalid), 1);
            check($sformatf("pkt_tdata_%0d", i), m_tdata, DW'(i));
            check($sformatf("pkt_tlast_%0d", i), DW'(m_tlast), DW'((i == 4) || (i == 8) || (i == 10)));
        end
        tick();
        check("pkt_drained", DW'(m_tvalid), 0);
        tick();
        check("pkt_state_done", DW'(state_o), DW'(DONE));
        ctrl_write(WFI_STOPPED, 0);
        check("pkt_state_idle", DW'(state_o), DW'(IDLE));

        // Halt coverage: halting on, sink stalled, CPU obeys halt_cpu
        ctrl_write(TLAST_INTERVAL, 0);
        ctrl_write(HALTING_ON_FULL_FIFO_ENABLED, 1);
        m_tready = 1'b0;
        start_trace();
        push_item(DW'(32'h21));
        check("halt_after_first_push", DW'(halt_cpu), 0);
        push_item(DW'(32'h22));
        check("halt_asserted", DW'(halt_cpu), 1);
        for (int k = 0; k < 4; k++) begin
            item_valid = !halt_cpu;
            item_data  = DW'(32'h23 + k);
            tick();
        end
        item_valid = 1'b0;
        check("halt_held", DW'(halt_cpu), 1);
        check("halt_no_drop", DW'(dropped_items), 0);
        check("halt_head", m_tdata, DW'(32'h21));
        m_tready = 1'b1;
        tick();
        check("halt_second", m_tdata, DW'(32'h22));
        tick();
        check("halt_only_two", DW'(m_tvalid), 0);
        m_tready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Drop path: halting off, sink stalled, 5 items
        start_trace();
        for (int i = 1; i <= 5; i++) push_item(DW'(32'h30 + i));
        check("drop_head", m_tdata, DW'(32'h31));
        check("drop_count", DW'(dropped_items), 3);
        ctrl_read_check("drop_reg", DROPPED_ITEMS_COUNT, 3);
        check("drop_no_halt", DW'(halt_cpu), 0);
        ctrl_write(ARBITRARY_HALT, 1);
        tick();
        check("arb_halt", DW'(halt_cpu), 1);

        // Reset mid-stream with 2 beats queued
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_tvalid", DW'(m_tvalid), 0);
        check("mrst_halt", DW'(halt_cpu), 0);
        check("mrst_state", DW'(state_o), DW'(IDLE));
        check("mrst_dropped", DW'(dropped_items), 0);

        // Empty flush: 3 items popped, then WFI closes the packet with a marker beat
        m_tready = 1'b1;
        start_trace();
        for (int i = 1; i <= 3; i++) begin
            push_item(DW'(32'h40 + i));
            check($sformatf("ef_tlast_%0d", i), DW'(m_tlast), 0);
        end
        tick();
        check("ef_empty", DW'(m_tvalid), 0);
        wfi_detected = 1'b1;
        tick();
        wfi_detected = 1'b0;
        check("ef_state_flush", DW'(state_o), DW'(FLUSH));
        check("ef_marker_valid", DW'(m_tvalid), 1);
        check("ef_marker_data", m_tdata, 0);
        check("ef_marker_last", DW'(m_tlast), 1);
        ctrl_read_check("ef_wfi_set", WFI_STOPPED, 1);
        tick();
        check("ef_state_done", DW'(state_o), DW'(DONE));
        check("ef_after_marker", DW'(m_tvalid), 0);
        ctrl_write(WFI_STOPPED, 0);
        check("ef_state_idle", DW'(state_o), DW'(IDLE));
        ctrl_read_check("ef_wfi_clr", WFI_STOPPED, 0);

        // Registers: counter load, pop timestamp, unmapped read, write/read same cycle
        m_tready = 1'b0;
        start_trace();
        push_item(DW'(32'h51));
        ctrl_write(CLK_COUNTER, 64'h100);
        ctrl_read_check("reg_clk_load", CLK_COUNTER, 64'h100);
        for (int k = 0; k < 5; k++) tick();
        m_tready = 1'b1;
        tick();
        m_tready = 1'b0;
        check("reg_popped", DW'(m_tvalid), 0);
        ctrl_read_check("reg_last_ts", LAST_WRITE_TIMESTAMP, 64'h105);
        ctrl_read_check("reg_unmapped", 8'hFF, 0);
        ctrl_addr  = TLAST_INTERVAL;
        ctrl_wdata = 64'd7;
        ctrl_we    = 1'b1;
        #1;
        check("reg_rw_old", DW'(ctrl_rdata), 0);
        tick();
        ctrl_we = 1'b0;
        ctrl_read_check("reg_rw_new", TLAST_INTERVAL, 7);

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
